// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the cpu_sequencer block: state encoding,
// decoder control bundle layout, store mask and memory-wait timeout.
package cpu_seq_pkg;

    localparam int unsigned CTRL_W = 10;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned TMR_W  = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OPC_STP = 5'b11111;
    localparam logic [TMR_W-1:0] TIMEOUT = 4'd15;

    localparam int unsigned IDX_INSTR_WEN2 = 9;
    localparam int unsigned IDX_DATA_WEN1  = 8;
    localparam int unsigned IDX_DATA_WEN2  = 7;
    localparam int unsigned IDX_RD_WEN     = 6;
    localparam int unsigned IDX_RS_WEN     = 5;
    localparam int unsigned IDX_MOVE_FP    = 4;
    localparam int unsigned IDX_PUSH_UP    = 3;
    localparam int unsigned IDX_CNT_EN     = 2;
    localparam int unsigned IDX_PC_SLOAD   = 1;
    localparam int unsigned IDX_RSMUX_SEL  = 0;

    localparam logic [CTRL_W-1:0] STORE_MASK = 10'b1110000000;
    // Bits that stay asserted while a store waits for memory.
    localparam logic [CTRL_W-1:0] WAIT_MASK  = 10'b1110000001;

    typedef struct packed {
        logic instr_wen2;
        logic data_wen1;
        logic data_wen2;
        logic rd_wen;
        logic rs_wen;
        logic move_fp;
        logic push_up;
        logic cnt_en;
        logic pc_sload;
        logic rsmux_sel;
    } ctrl_t;

    function automatic logic has_store(input ctrl_t c);
        return |(CTRL_W'(c) & STORE_MASK);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait counter: cleared outside MEMWAIT, counts waiting cycles and
// flags the cycle whose increment reaches TIMEOUT.
module mem_wait_timer
    import cpu_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TIMEOUT)) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expired = enable && (count == (TIMEOUT - TMR_W'(1)));

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch/decode/exec with store wait and timeout.
// Optional feature macro: CPU_SEQ_CYCLE_COUNT_EN enables the busy-cycle counter.
module cpu_sequencer
    import cpu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [CTRL_W-1:0] dec_ctrl,
    input  logic              mem_ready,
    output logic              ir_load,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic              busy,
    output logic              halted,
    output logic              mem_err,
    output logic [CNT_W-1:0]  cycle_count
);

    state_t state, state_nxt;
    ctrl_t  ctl_r;
    logic   rsmux_in;
    logic   store_pend;
    logic   expired;
    logic   mem_err_r;

    mem_wait_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != S_MEMWAIT),
        .enable  ((state == S_MEMWAIT) && !mem_ready),
        .expired (expired)
    );

    // An unknown rsmux_sel from the decoder is captured as 0.
    always_comb begin
        rsmux_in = 1'b0;
        if (dec_ctrl[IDX_RSMUX_SEL] == 1'b1) begin
            rsmux_in = 1'b1;
        end
    end

    assign store_pend = has_store(ctl_r) && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ctl_r     <= '0;
            mem_err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                ctl_r <= ctrl_t'({dec_ctrl[CTRL_W-1:1], rsmux_in});
            end
            if ((state == S_MEMWAIT) && expired) begin
                mem_err_r <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (run) state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE:  state_nxt = (opcode == OPC_STP) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (store_pend) state_nxt = S_MEMWAIT;
                else            state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_MEMWAIT: begin
                if (mem_ready)    state_nxt = run ? S_FETCH : S_IDLE;
                else if (expired) state_nxt = S_HALT;
            end
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // While a store waits, only store bits and rsmux_sel are driven.
    always_comb begin
        ir_load = 1'b0;
        ctrl_q  = '0;
        busy    = 1'b0;
        halted  = 1'b0;
        case (state)
            S_FETCH: begin
                ir_load = 1'b1;
                busy    = 1'b1;
            end
            S_DECODE: busy = 1'b1;
            S_EXEC, S_MEMWAIT: begin
                busy   = 1'b1;
                ctrl_q = store_pend ? (CTRL_W'(ctl_r) & WAIT_MASK) : CTRL_W'(ctl_r);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_err = mem_err_r;

`ifdef CPU_SEQ_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_r <= '0;
        end else if (busy && (cycle_r != {CNT_W{1'b1}})) begin
            cycle_r <= cycle_r + CNT_W'(1);
        end
    end

    assign cycle_count = cycle_r;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table plus
// hand-written timeout, timeout race, run-drop and reset-abandon sequences.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [4:0] opcode;
    logic [9:0] dec_ctrl;
    logic       mem_ready;
    logic       ir_load;
    logic [9:0] ctrl_q;
    logic       busy;
    logic       halted;
    logic       mem_err;
    logic [15:0] cycle_count;

    int checks;
    int failures;

    cpu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .dec_ctrl    (dec_ctrl),
        .mem_ready   (mem_ready),
        .ir_load     (ir_load),
        .ctrl_q      (ctrl_q),
        .busy        (busy),
        .halted      (halted),
        .mem_err     (mem_err),
        .cycle_count (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [4:0] opcode;
        logic [9:0] dec_ctrl;
        logic       mem_ready;
        logic       exp_ir;
        logic [9:0] exp_ctrl;
        logic       exp_busy;
        logic       exp_halted;
        logic       exp_err;
    } vec_t;

    localparam logic [4:0] OP  = 5'b01000;
    localparam logic [4:0] STP = 5'b11111;
    localparam logic [9:0] D1  = 10'b0001000100;
    localparam logic [9:0] D2  = 10'b0100000100;
    localparam logic [9:0] D2W = 10'b0100000000;
    localparam logic [9:0] D3  = 10'b1000100001;
    localparam logic [9:0] D3W = 10'b1000000001;
    localparam logic [9:0] D4  = 10'b0010000100;
    localparam logic [9:0] D4W = 10'b0010000000;
    localparam logic [9:0] Z   = 10'b0000000000;

    function automatic vec_t mk(logic rn, logic r, logic [4:0] op, logic [9:0] dc,
                                logic mr, logic ei, logic [9:0] ec, logic eb,
                                logic eh, logic ee);
        vec_t v;
        v.rst_n = rn; v.run = r; v.opcode = op; v.dec_ctrl = dc; v.mem_ready = mr;
        v.exp_ir = ei; v.exp_ctrl = ec; v.exp_busy = eb; v.exp_halted = eh; v.exp_err = ee;
        return v;
    endfunction

    // Drive one cycle's inputs, compare outputs mid-cycle, end just after the next edge.
    task automatic apply(input vec_t v, input string nm);
        logic [13:0] exp_v;
        logic [13:0] act_v;
        rst_n     = v.rst_n;
        run       = v.run;
        opcode    = v.opcode;
        dec_ctrl  = v.dec_ctrl;
        mem_ready = v.mem_ready;
        @(negedge clk);
        exp_v = {v.exp_ir, v.exp_ctrl, v.exp_busy, v.exp_halted, v.exp_err};
        act_v = {ir_load, ctrl_q, busy, halted, mem_err};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: ir/ctrl/busy/halt/err got %b expected %b", nm, act_v, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cc(input string nm, input logic [15:0] on_val);
        logic [15:0] exp_cc;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
        exp_cc = on_val;
`else
        exp_cc = 16'h0000;
        if (on_val == 16'hFFFF) exp_cc = 16'h0001;
`endif
        checks++;
        if (cycle_count !== exp_cc) begin
            failures++;
            $display("FAIL %s: cycle_count got %0d expected %0d", nm, cycle_count, exp_cc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = OP; dec_ctrl = Z;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; run = 1'b0; opcode = OP; dec_ctrl = Z; mem_ready = 1'b0;
        @(posedge clk);
        do_reset();
        check_cc("reset_cycle_count", 16'h0000);

        // rn run op dc mr | ir ctrl busy halt err
        tbl.push_back(mk(1, 1, OP,  D1, 0, 0, Z,   0, 0, 0)); // IDLE
        tbl.push_back(mk(1, 1, OP,  D1, 0, 1, Z,   1, 0, 0)); // FETCH
        tbl.push_back(mk(1, 1, OP,  D1, 0, 0, Z,   1, 0, 0)); // DECODE
        tbl.push_back(mk(1, 1, OP,  D2, 0, 0, D1,  1, 0, 0)); // EXEC, no store
        tbl.push_back(mk(1, 1, OP,  D2, 0, 1, Z,   1, 0, 0)); // FETCH
        tbl.push_back(mk(1, 1, OP,  D2, 0, 0, Z,   1, 0, 0)); // DECODE
        tbl.push_back(mk(1, 1, OP,  D2, 0, 0, D2W, 1, 0, 0)); // EXEC stalls
        tbl.push_back(mk(1, 1, OP,  D2, 0, 0, D2W, 1, 0, 0)); // MEMWAIT
        tbl.push_back(mk(1, 1, OP,  D2, 0, 0, D2W, 1, 0, 0)); // MEMWAIT
        tbl.push_back(mk(1, 0, OP,  D2, 1, 0, D2,  1, 0, 0)); // ready: cnt_en once
        tbl.push_back(mk(1, 0, OP,  D3, 0, 0, Z,   0, 0, 0)); // IDLE
        tbl.push_back(mk(1, 1, OP,  D3, 0, 0, Z,   0, 0, 0)); // IDLE -> FETCH
        tbl.push_back(mk(1, 1, OP,  D3, 0, 1, Z,   1, 0, 0)); // FETCH
        tbl.push_back(mk(1, 1, OP,  D3, 0, 0, Z,   1, 0, 0)); // DECODE
        tbl.push_back(mk(1, 1, OP,  D3, 0, 0, D3W, 1, 0, 0)); // EXEC: iw2+rsmux only
        tbl.push_back(mk(1, 0, OP,  D3, 1, 0, D3,  1, 0, 0)); // MEMWAIT done
        tbl.push_back(mk(1, 1, OP,  D2, 1, 0, Z,   0, 0, 0)); // IDLE
        tbl.push_back(mk(1, 1, OP,  D2, 1, 1, Z,   1, 0, 0)); // FETCH
        tbl.push_back(mk(1, 1, OP,  D2, 1, 0, Z,   1, 0, 0)); // DECODE
        tbl.push_back(mk(1, 0, OP,  D2, 1, 0, D2,  1, 0, 0)); // store ready in EXEC
        tbl.push_back(mk(1, 1, STP, Z,  0, 0, Z,   0, 0, 0)); // IDLE
        tbl.push_back(mk(1, 1, STP, Z,  0, 1, Z,   1, 0, 0)); // FETCH
        tbl.push_back(mk(1, 1, STP, D1, 0, 0, Z,   1, 0, 0)); // DECODE STP
        tbl.push_back(mk(1, 1, OP,  D1, 1, 0, Z,   0, 1, 0)); // HALT
        tbl.push_back(mk(1, 0, OP,  D1, 1, 0, Z,   0, 1, 0)); // HALT ignores run
        tbl.push_back(mk(0, 0, OP,  D1, 0, 0, Z,   0, 1, 0)); // reset sampled here
        tbl.push_back(mk(1, 0, OP,  D1, 0, 0, Z,   0, 0, 0)); // IDLE

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Store timeout: EXEC + 15 wait cycles, then HALT with mem_err.
        do_reset();
        apply(mk(1, 1, OP, D4, 0, 0, Z,   0, 0, 0), "to_idle");
        apply(mk(1, 1, OP, D4, 0, 1, Z,   1, 0, 0), "to_fetch");
        apply(mk(1, 1, OP, D4, 0, 0, Z,   1, 0, 0), "to_decode");
        apply(mk(1, 1, OP, D4, 0, 0, D4W, 1, 0, 0), "to_exec");
        for (int k = 1; k <= 15; k++) begin
            apply(mk(1, logic'(k % 2), OP, D4, 0, 0, D4W, 1, 0, 0), $sformatf("to_wait%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            apply(mk(1, logic'(k % 2), OP, D1, 0, 0, Z, 0, 1, 1), $sformatf("to_halt%0d", k));
        end
        check_cc("to_cycle_count", 16'd18);
        do_reset();
        apply(mk(1, 0, OP, D1, 0, 0, Z, 0, 0, 0), "to_reset_clears");

        // mem_ready in the timeout cycle completes the instruction.
        do_reset();
        apply(mk(1, 1, OP, D4, 0, 0, Z,   0, 0, 0), "race_idle");
        apply(mk(1, 1, OP, D4, 0, 1, Z,   1, 0, 0), "race_fetch");
        apply(mk(1, 1, OP, D4, 0, 0, Z,   1, 0, 0), "race_decode");
        apply(mk(1, 1, OP, D4, 0, 0, D4W, 1, 0, 0), "race_exec");
        for (int k = 1; k <= 14; k++) begin
            apply(mk(1, 1, OP, D4, 0, 0, D4W, 1, 0, 0), $sformatf("race_wait%0d", k));
        end
        apply(mk(1, 0, OP, D4, 1, 0, D4,  1, 0, 0), "race_done");
        apply(mk(1, 0, OP, D4, 0, 0, Z,   0, 0, 0), "race_idle_after");

        // run dropped during DECODE still completes, then IDLE.
        do_reset();
        apply(mk(1, 1, OP, D1, 0, 0, Z,  0, 0, 0), "rd_idle");
        apply(mk(1, 1, OP, D1, 0, 1, Z,  1, 0, 0), "rd_fetch");
        apply(mk(1, 0, OP, D1, 0, 0, Z,  1, 0, 0), "rd_decode");
        apply(mk(1, 0, OP, D1, 0, 0, D1, 1, 0, 0), "rd_exec");
        check_cc("rd_cycle_count", 16'd3);
        apply(mk(1, 0, OP, D1, 0, 0, Z,  0, 0, 0), "rd_idle_after");
        check_cc("rd_cycle_hold", 16'd3);

        // Reset while waiting on memory abandons the instruction.
        do_reset();
        apply(mk(1, 1, OP, D2, 0, 0, Z,   0, 0, 0), "rw_idle");
        apply(mk(1, 1, OP, D2, 0, 1, Z,   1, 0, 0), "rw_fetch");
        apply(mk(1, 1, OP, D2, 0, 0, Z,   1, 0, 0), "rw_decode");
        apply(mk(1, 1, OP, D2, 0, 0, D2W, 1, 0, 0), "rw_exec");
        apply(mk(1, 1, OP, D2, 0, 0, D2W, 1, 0, 0), "rw_wait");
        apply(mk(0, 1, OP, D2, 0, 0, D2W, 1, 0, 0), "rw_reset_edge");
        apply(mk(1, 0, OP, D2, 1, 0, Z,   0, 0, 0), "rw_after_reset");
        check_cc("rw_cycle_count", 16'h0000);
        apply(mk(1, 0, OP, D2, 1, 0, Z,   0, 0, 0), "rw_idle_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset: clk, and rst_n, which is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
REQ-005 opcode  in  5  instr[15:11] of the current instruction; 5'b11111 = STP.
REQ-006 dec_ctrl  in  10  decoder control bundle {instr_wen2, data_wen1, data_wen2, rd_wen, rs_wen, move_fp, push_up, cnt_en, pc_sload, rsmux_sel}.
REQ-007 mem_ready  in  1  memory accepts the asserted store this cycle.
REQ-008 ir_load  out  1  instruction register load strobe.
REQ-009 ctrl_q  out  10  gated control bundle in dec_ctrl bit order; these are the strobes that drive the datapath.
REQ-010 busy  out  1  high in FETCH, DECODE, EXEC and MEMWAIT.
REQ-011 halted  out  1  high in HALT.
REQ-012 mem_err  out  1  sticky; set on store timeout.
REQ-013 cycle_count  out  16  count of active cycles.

Function
REQ-014 The block SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEMWAIT and HALT.
REQ-015 IDLE: all strobes are 0; run=1 moves to FETCH on the next edge.
REQ-016 FETCH: ir_load=1 for exactly one cycle, then DECODE.
REQ-017 DECODE: dec_ctrl is captured into an internal register ctl_r with all strobes low.
  - Next state is HALT if opcode==5'b11111, otherwise EXEC.
  - Instruction latency is 3 cycles when there is no memory wait.
REQ-018 EXEC: ctrl_q=ctl_r for one cycle.
  - If any store bit (instr_wen2, data_wen1, data_wen2) is set and mem_ready=0, the block moves to MEMWAIT.
  - In that case only the store bits and rsmux_sel are driven; the register, PC and fp bits are held 0.
REQ-019 MEMWAIT: the store bits and rsmux_sel stay asserted until mem_ready=1.
  - In the mem_ready cycle, the remaining ctl_r bits assert for exactly one cycle and the instruction completes.
REQ-020 On completion (EXEC without a wait, or MEMWAIT with mem_ready=1), the next state is FETCH if run=1, otherwise IDLE.
REQ-021 Deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-022 Each of rd_wen, rs_wen, cnt_en, pc_sload, move_fp and push_up SHALL pulse at most once per instruction.
REQ-023 rsmux_sel SHALL be held from EXEC through completion; an X input is treated as 0.
REQ-024 MEMWAIT timeout: a 4-bit wait counter starts at 0 on MEMWAIT entry.
  - When it reaches TIMEOUT=15 without mem_ready, the block sets mem_err, drops all strobes and enters HALT.
  - mem_ready arriving in the same cycle as the timeout wins: the instruction completes normally.
REQ-025 HALT: halted=1 and all strobes are 0; HALT is left only by reset, and run is ignored.

Reset
REQ-026 While rst_n=0 at a clk edge, the block SHALL enter IDLE and clear ctl_r, the wait counter, mem_err and cycle_count.
  - All outputs are 0 in the following cycle.
REQ-027 A reset during MEMWAIT or EXEC SHALL abandon the instruction with no further strobes.

Configuration
REQ-028 CPU_SEQ_CYCLE_COUNT_EN defined: cycle_count increments in every cycle in which busy=1.
  - It saturates at 16'hFFFF and holds its value in IDLE and HALT.
REQ-029 CPU_SEQ_CYCLE_COUNT_EN undefined: cycle_count is tied to 16'h0000 and no counter logic is present; all other behaviour is identical.

Structure
REQ-030 The package cpu_seq_pkg SHALL hold the following shared items:
  - the state enum;
  - OPC_STP=5'b11111;
  - TIMEOUT=4'd15;
  - the bit-index constants for the dec_ctrl bundle;
  - the store-bit mask 10'b1110000000.
REQ-031 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer (inputs clear/enable, output expired).

Verification
REQ-032 Reset, then run=1 with opcode=5'b01000 and dec_ctrl=10'b0001000100 -> ir_load in cycle 1, then ctrl_q=10'b0001000100 for one cycle in cycle 3, then FETCH again.
REQ-033 dec_ctrl=10'b0100000100 with mem_ready low for 3 cycles -> data_wen1 high for 4 cycles; cnt_en pulses once in the 4th cycle (mem_ready=1); no stuck strobes.
REQ-034 Store with mem_ready held 0 -> mem_err=1 and halted=1 after EXEC plus 15 wait cycles; ctrl_q=0 thereafter; run toggling has no effect.
REQ-035 opcode=5'b11111 -> HALT after DECODE with no strobes; rst_n=0 for 1 cycle -> IDLE and all outputs 0.
REQ-036 run dropped during DECODE -> instruction completes, then IDLE; with CPU_SEQ_CYCLE_COUNT_EN defined, cycle_count=3; undefined, cycle_count=0.
